mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-access stage: decodes control codes into a held memory
//               request (kernel mem / picture RAM / pixel ROM) and returns the
//               read data. Optional ack timeout enabled by MEMU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ctrl_i,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic [1:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic [17:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [6:0] CODE_NOP  = 7'b0000000;
  localparam logic [6:0] CODE_KRD0 = 7'b1100010;
  localparam logic [6:0] CODE_KRD1 = 7'b1101010;
  localparam logic [6:0] CODE_PWR  = 7'b0100001;
  localparam logic [6:0] CODE_PRD  = 7'b1001110;

  localparam logic [1:0] SEL_KERNEL = 2'b00;
  localparam logic [1:0] SEL_PICRAM = 2'b01;
  localparam logic [1:0] SEL_PIXROM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic        legal;
  logic [1:0]  sel_d;
  logic        we_d;
  logic [17:0] addr_d;
  logic        read_d;
  logic        kernel_d;
  logic        accept;
  logic        illegal;
  logic        timeout_hit;
  logic        read_q;
  logic        kernel_q;

  // Upper address/data bits have no destination in this memory map.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:18], wdata_i[31:8]};

  always_comb begin
    legal    = 1'b1;
    sel_d    = SEL_KERNEL;
    we_d     = 1'b0;
    addr_d   = addr_i[17:0];
    read_d   = 1'b0;
    kernel_d = 1'b0;
    case (ctrl_i)
      CODE_KRD0: begin
        addr_d   = {1'b0, addr_i[16:0]};
        read_d   = 1'b1;
        kernel_d = 1'b1;
      end
      CODE_KRD1: begin
        addr_d   = {1'b1, addr_i[16:0]};
        read_d   = 1'b1;
        kernel_d = 1'b1;
      end
      CODE_PWR: begin
        sel_d = SEL_PICRAM;
        we_d  = 1'b1;
      end
      CODE_PRD: begin
        sel_d  = SEL_PIXROM;
        read_d = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && valid_i && legal;
  assign illegal = (state == IDLE) && valid_i && !legal && (ctrl_i != CODE_NOP);

`ifdef MEMU_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcount;

  assign timeout_hit = (state == REQ) && !mem_ack_i && (tcount == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount <= '0;
    end else if (accept) begin
      tcount <= '0;
    end else if ((state == REQ) && !mem_ack_i && !timeout_hit) begin
      tcount <= tcount + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // Timeout limit has no effect when the timeout feature is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall is raised in the accepting cycle itself, so it cannot wait for a register.
  assign stall_o       = rst_n && (accept || (state == REQ));
  assign mem_req_o     = (state == REQ);
  assign rdata_valid_o = (state == DONE) && read_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o       <= 1'b0;
      mem_sel_o   <= 2'b00;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 18'h0;
      mem_wdata_o <= 8'h0;
      read_q      <= 1'b0;
      kernel_q    <= 1'b0;
      rdata_o     <= 32'h0;
    end else begin
      err_o <= illegal || timeout_hit;
      if (accept) begin
        mem_sel_o   <= sel_d;
        mem_we_o    <= we_d;
        mem_addr_o  <= addr_d;
        mem_wdata_o <= we_d ? wdata_i[7:0] : 8'h0;
        read_q      <= read_d;
        kernel_q    <= kernel_d;
      end
      if ((state == REQ) && mem_ack_i && read_q) begin
        rdata_o <= kernel_q ? mem_rdata_i : {24'h0, mem_rdata_i[7:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [6:0]  ctrl_i;
  logic        valid_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;
  logic        mem_req_o;
  logic [1:0]  mem_sel_o;
  logic        mem_we_o;
  logic [17:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] KRD0 = 7'b1100010;
  localparam logic [6:0] KRD1 = 7'b1101010;
  localparam logic [6:0] PWR  = 7'b0100001;
  localparam logic [6:0] PRD  = 7'b1001110;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_i        (ctrl_i),
    .valid_i       (valid_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_sel_o     (mem_sel_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] c, input logic [31:0] a, input logic [31:0] d);
    valid_i = v;
    ctrl_i  = c;
    addr_i  = a;
    wdata_i = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    #1;
    check("reset_req",    {31'h0, mem_req_o},     32'h0);
    check("reset_stall",  {31'h0, stall_o},       32'h0);
    check("reset_rdata",  rdata_o,                32'h0);
    check("reset_rvalid", {31'h0, rdata_valid_o}, 32'h0);
    check("reset_err",    {31'h0, err_o},         32'h0);
    check("reset_addr",   {14'h0, mem_addr_o},    32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // KRD0, ack at cycle 3
    drive(1'b1, KRD0, 32'h0000_0040, 32'h0);
    #1;
    check("krd0_c0_stall", {31'h0, stall_o},   32'h1);
    check("krd0_c0_req",   {31'h0, mem_req_o}, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    #1;
    check("krd0_c1_req",   {31'h0, mem_req_o},  32'h1);
    check("krd0_c1_sel",   {30'h0, mem_sel_o},  32'h0);
    check("krd0_c1_addr",  {14'h0, mem_addr_o}, 32'h0000_0040);
    check("krd0_c1_we",    {31'h0, mem_we_o},   32'h0);
    check("krd0_c1_stall", {31'h0, stall_o},    32'h1);
    tick();
    check("krd0_c2_stall", {31'h0, stall_o},    32'h1);
    check("krd0_c2_rval",  {31'h0, rdata_valid_o}, 32'h0);
    tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    #1;
    check("krd0_c3_stall", {31'h0, stall_o},   32'h1);
    check("krd0_c3_req",   {31'h0, mem_req_o}, 32'h1);
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("krd0_c4_rval",  {31'h0, rdata_valid_o}, 32'h1);
    check("krd0_c4_rdata", rdata_o,                 32'h1234_5678);
    check("krd0_c4_stall", {31'h0, stall_o},        32'h0);
    check("krd0_c4_req",   {31'h0, mem_req_o},      32'h0);
    tick();
    check("krd0_c5_rval",  {31'h0, rdata_valid_o}, 32'h0);
    check("krd0_c5_hold",  rdata_o,                 32'h1234_5678);

    // KRD1, ack in first REQ cycle; upper address bits ignored
    drive(1'b1, KRD1, 32'hFFFE_0005, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    #1;
    check("krd1_addr", {14'h0, mem_addr_o}, 32'h0002_0005);
    check("krd1_req",  {31'h0, mem_req_o},  32'h1);
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("krd1_c2_rval",  {31'h0, rdata_valid_o}, 32'h1);
    check("krd1_c2_rdata", rdata_o,                 32'hCAFE_F00D);
    tick();

    // PWR; a PRD offered during REQ must be ignored
    drive(1'b1, PWR, 32'h0001_F000, 32'h1234_56AB);
    tick();
    drive(1'b1, PRD, 32'h0003_FFFF, 32'h0);
    #1;
    check("pwr_c1_sel",   {30'h0, mem_sel_o},   32'h1);
    check("pwr_c1_we",    {31'h0, mem_we_o},    32'h1);
    check("pwr_c1_wdata", {24'h0, mem_wdata_o}, 32'h0000_00AB);
    check("pwr_c1_addr",  {14'h0, mem_addr_o},  32'h0001_F000);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    mem_ack_i = 1'b1;
    #1;
    check("pwr_c2_wdata", {24'h0, mem_wdata_o}, 32'h0000_00AB);
    check("pwr_c2_addr",  {14'h0, mem_addr_o},  32'h0001_F000);
    check("pwr_c2_sel",   {30'h0, mem_sel_o},   32'h1);
    tick();
    mem_ack_i = 1'b0;
    #1;
    check("pwr_c3_rval",  {31'h0, rdata_valid_o}, 32'h0);
    check("pwr_c3_hold",  rdata_o,                 32'hCAFE_F00D);
    check("pwr_c3_stall", {31'h0, stall_o},        32'h0);
    tick();
    check("pwr_c4_noreq", {31'h0, mem_req_o}, 32'h0);

    // PRD returns only the low byte
    drive(1'b1, PRD, 32'h0003_FFFF, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FF7E;
    #1;
    check("prd_sel",  {30'h0, mem_sel_o},  32'h2);
    check("prd_addr", {14'h0, mem_addr_o}, 32'h0003_FFFF);
    check("prd_we",   {31'h0, mem_we_o},   32'h0);
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("prd_rval",  {31'h0, rdata_valid_o}, 32'h1);
    check("prd_rdata", rdata_o,                 32'h0000_007E);
    tick();

    // Illegal code
    drive(1'b1, 7'b0000001, 32'h0000_1234, 32'h0);
    #1;
    check("ill_c0_stall", {31'h0, stall_o}, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    #1;
    check("ill_c1_err",   {31'h0, err_o},     32'h1);
    check("ill_c1_req",   {31'h0, mem_req_o}, 32'h0);
    check("ill_c1_stall", {31'h0, stall_o},   32'h0);
    tick();
    check("ill_c2_err",   {31'h0, err_o},     32'h0);
    check("ill_c2_req",   {31'h0, mem_req_o}, 32'h0);

    // Ack while idle is ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("idleack_rval",  {31'h0, rdata_valid_o}, 32'h0);
    check("idleack_rdata", rdata_o,                 32'h0000_007E);
    check("idleack_req",   {31'h0, mem_req_o},      32'h0);

    // Reset during REQ
    tick();
    drive(1'b1, KRD0, 32'h0000_0123, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    #1;
    check("rstreq_pre_req", {31'h0, mem_req_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstreq_req",   {31'h0, mem_req_o},  32'h0);
    check("rstreq_stall", {31'h0, stall_o},    32'h0);
    check("rstreq_addr",  {14'h0, mem_addr_o}, 32'h0);
    check("rstreq_rdata", rdata_o,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstreq_after_req", {31'h0, mem_req_o}, 32'h0);

`ifdef MEMU_TIMEOUT_EN
    // No ack: abort after 4 REQ cycles
    drive(1'b1, KRD0, 32'h0000_0010, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req_c%0d", i), {31'h0, mem_req_o}, 32'h1);
      check($sformatf("to_err_c%0d", i), {31'h0, err_o},     32'h0);
      tick();
    end
    check("to_c5_req",   {31'h0, mem_req_o},      32'h0);
    check("to_c5_err",   {31'h0, err_o},          32'h1);
    check("to_c5_rval",  {31'h0, rdata_valid_o},  32'h0);
    check("to_c5_stall", {31'h0, stall_o},        32'h0);
    tick();
    check("to_c6_err",   {31'h0, err_o},          32'h0);
    check("to_c6_req",   {31'h0, mem_req_o},      32'h0);
`else
    // Without the timeout, REQ waits for the ack
    drive(1'b1, KRD0, 32'h0000_0010, 32'h0);
    tick();
    drive(1'b0, 7'h0, 32'h0, 32'h0);
    repeat (10) tick();
    check("wait_req", {31'h0, mem_req_o}, 32'h1);
    check("wait_err", {31'h0, err_o},     32'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0BAD_BEEF;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check("wait_rval",  {31'h0, rdata_valid_o}, 32'h1);
    check("wait_rdata", rdata_o,                 32'h0BAD_BEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
